dc_ipu_filter_core_mc: RTL and testbench

// Multi-channel, parametrised successor of the IPU 4x4 filter core. Applies one shared signed

---
 rtl/dc_ipu_filter_core_mc.sv | 166 ++++++++++++++++
 tb/tb_dc_ipu_filter_core_mc.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/dc_ipu_filter_core_mc.sv
// dc_ipu_filter_core_mc
// Multi-channel TAPS x TAPS weighted filter. One signed kernel is shared by all
// colour channels; each beat produces one rounded, clamped pixel per channel.
// Three pipeline stages: S0 multiply, S1 row sums, S2 column sum + round/clamp.
//
// Handshake: a beat moves across an interface on a rising edge where valid and
// ready are both 1. A producer keeps valid and data stable until that edge, and
// ready may depend combinationally on the downstream ready (no skid buffer).

module dc_ipu_filter_core_mc #(
    parameter int TAPS               = 4,
    parameter int CHANNELS           = 3,
    parameter int COLOR_WIDTH        = 8,
    parameter int WEIGHT_WIDTH       = 16,
    parameter int WEIGHT_FRACT_WIDTH = 14
) (
    input  logic                           clk,
    input  logic                           nreset,
    input  logic                           clr,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic                           in_bypass,
    input  logic signed [WEIGHT_WIDTH-1:0] weights_matrix [TAPS][TAPS],
    input  logic        [COLOR_WIDTH-1:0]  texel_matrix   [CHANNELS][TAPS][TAPS],
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic        [COLOR_WIDTH-1:0]  pixel_data     [CHANNELS],
    output logic        [CHANNELS-1:0]     out_clamped
);

    // Product, row-sum and column-sum widths; the guard bits make overflow impossible.
    localparam int GW  = $clog2(TAPS);
    localparam int PW  = COLOR_WIDTH + 1 + WEIGHT_WIDTH;
    localparam int RW  = PW + GW;
    localparam int SW  = RW + GW;
    localparam int CTR = TAPS / 2 - 1;

    localparam logic signed [SW-1:0] ROUND   = SW'(1) <<< (WEIGHT_FRACT_WIDTH - 1);
    localparam logic signed [SW-1:0] PIX_MAX = SW'((1 << COLOR_WIDTH) - 1);

    // Stage valids
    logic v0_q, v1_q, v2_q;

    // Stage load enables: a stage loads when empty or when its content moves on
    logic en0, en1, en2;

    // S0 registers
    logic signed [PW-1:0]          prod_q [CHANNELS][TAPS][TAPS];
    logic signed [PW-1:0]          prod_d [CHANNELS][TAPS][TAPS];
    logic                          byp0_q;
    logic        [COLOR_WIDTH-1:0] ctr0_q [CHANNELS];
    logic        [COLOR_WIDTH-1:0] ctr_d  [CHANNELS];

    // S1 registers
    logic signed [RW-1:0]          row_q  [CHANNELS][TAPS];
    logic signed [RW-1:0]          row_d  [CHANNELS][TAPS];
    logic                          byp1_q;
    logic        [COLOR_WIDTH-1:0] ctr1_q [CHANNELS];

    // S2 registers (visible outputs)
    logic        [COLOR_WIDTH-1:0] pix_q   [CHANNELS];
    logic        [COLOR_WIDTH-1:0] pix_d   [CHANNELS];
    logic        [CHANNELS-1:0]    clamp_q;
    logic        [CHANNELS-1:0]    clamp_d;

    assign en2      = !v2_q || out_ready;
    assign en1      = !v1_q || en2;
    assign en0      = !v0_q || en1;
    assign in_ready = en0 && !clr;

    assign out_valid   = v2_q;
    assign pixel_data  = pix_q;
    assign out_clamped = clamp_q;

    // Valid chain: flush on clr, otherwise advance each stage when it may load
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            v0_q <= 1'b0;
            v1_q <= 1'b0;
            v2_q <= 1'b0;
        end else if (clr) begin
            v0_q <= 1'b0;
            v1_q <= 1'b0;
            v2_q <= 1'b0;
        end else begin
            if (en0) v0_q <= in_valid;
            if (en1) v1_q <= v0_q;
            if (en2) v2_q <= v1_q;
        end
    end

    // S0 datapath: signed products of zero-extended texels and weights, centre texel tap
    always_comb begin
        for (int c = 0; c < CHANNELS; c++) begin
            ctr_d[c] = texel_matrix[c][CTR][CTR];
            for (int r = 0; r < TAPS; r++) begin
                for (int t = 0; t < TAPS; t++) begin
                    prod_d[c][r][t] = PW'($signed({1'b0, texel_matrix[c][r][t]}))
                                    * PW'(weights_matrix[r][t]);
                end
            end
        end
    end

    // S1 datapath: sum each kernel row per channel
    always_comb begin
        for (int c = 0; c < CHANNELS; c++) begin
            for (int r = 0; r < TAPS; r++) begin
                row_d[c][r] = '0;
                for (int t = 0; t < TAPS; t++) begin
                    row_d[c][r] = row_d[c][r] + RW'(prod_q[c][r][t]);
                end
            end
        end
    end

    // S2 datapath: column sum, round half up, drop fraction, clamp or bypass
    always_comb begin
        logic signed [SW-1:0] col;
        logic signed [SW-1:0] shf;
        clamp_d = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            col = '0;
            for (int r = 0; r < TAPS; r++) begin
                col = col + SW'(row_q[c][r]);
            end
            shf = (col + ROUND) >>> WEIGHT_FRACT_WIDTH;
            pix_d[c] = shf[COLOR_WIDTH-1:0];
            if (byp1_q) begin
                pix_d[c] = ctr1_q[c];
            end else if (shf < 0) begin
                pix_d[c]   = '0;
                clamp_d[c] = 1'b1;
            end else if (shf > PIX_MAX) begin
                pix_d[c]   = '1;
                clamp_d[c] = 1'b1;
            end
        end
    end

    // S0/S1 data registers follow their stage enables; contents only matter when valid
    always_ff @(posedge clk) begin
        if (en0) begin
            prod_q <= prod_d;
            byp0_q <= in_bypass;
            ctr0_q <= ctr_d;
        end
        if (en1) begin
            row_q  <= row_d;
            byp1_q <= byp0_q;
            ctr1_q <= ctr0_q;
        end
    end

    // S2 output registers: reset to zero, hold while the sink stalls
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            pix_q   <= '{default: '0};
            clamp_q <= '0;
        end else if (en2) begin
            pix_q   <= pix_d;
            clamp_q <= clamp_d;
        end
    end

endmodule

// File: tb/tb_dc_ipu_filter_core_mc.sv
// Self-checking bench for dc_ipu_filter_core_mc: directed beats with hand-computed
// pixels, scoreboard queue filled at acceptance and drained by an output monitor.

module tb_dc_ipu_filter_core_mc;

    localparam int T  = 4;
    localparam int CH = 3;
    localparam int CW = 8;
    localparam int WW = 16;

    // Clock / reset block
    logic clk = 1'b0;
    logic nreset;
    always #5 clk = ~clk;

    logic                 clr, in_valid, in_ready, in_bypass, out_valid, out_ready;
    logic signed [WW-1:0] w   [T][T];
    logic        [CW-1:0] tex [CH][T][T];
    logic        [CW-1:0] pix [CH];
    logic        [CH-1:0] clamped;
    logic        [26:0]   got;

    assign got = {clamped, pix[2], pix[1], pix[0]};

    dc_ipu_filter_core_mc #(
        .TAPS(T), .CHANNELS(CH), .COLOR_WIDTH(CW), .WEIGHT_WIDTH(WW), .WEIGHT_FRACT_WIDTH(14)
    ) dut (
        .clk(clk), .nreset(nreset), .clr(clr),
        .in_valid(in_valid), .in_ready(in_ready), .in_bypass(in_bypass),
        .weights_matrix(w), .texel_matrix(tex),
        .out_valid(out_valid), .out_ready(out_ready),
        .pixel_data(pix), .out_clamped(clamped)
    );

    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;
    logic rnd_ready = 1'b0;

    // Scoreboard: expected beat and expected output cycle (-1 = no latency check)
    logic [26:0] exp_q[$];
    int          lat_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    function automatic logic [26:0] pk(input int p0, input int p1, input int p2,
                                       input logic [2:0] cl);
        return {cl, 8'(p2), 8'(p1), 8'(p0)};
    endfunction

    // Monitor: a transfer happens on the next rising edge when valid and ready are high
    always @(negedge clk) begin
        if (nreset && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_output actual=%h expected=none at cycle %0d", got, cyc);
            end else begin
                logic [26:0] e;
                int          l;
                e = exp_q.pop_front();
                l = lat_q.pop_front();
                check("out_beat", 32'(got), 32'(e));
                if (l >= 0) check("latency", 32'(cyc), 32'(l));
            end
        end
    end

    // Driver tasks
    task automatic set_w(input int v);
        for (int r = 0; r < T; r++)
            for (int t = 0; t < T; t++)
                w[r][t] = WW'(v);
    endtask

    task automatic set_tex(input int v);
        for (int c = 0; c < CH; c++)
            for (int r = 0; r < T; r++)
                for (int t = 0; t < T; t++)
                    tex[c][r][t] = CW'(v);
    endtask

    task automatic send_beat(input logic byp, input logic [26:0] e, input logic chk_lat);
        logic done;
        done      = 1'b0;
        in_valid  = 1'b1;
        in_bypass = byp;
        for (int i = 0; i < 50 && !done; i++) begin
            @(negedge clk);
            if (in_ready) begin
                exp_q.push_back(e);
                lat_q.push_back(chk_lat ? cyc + 3 : -1);
                done = 1'b1;
            end
            @(posedge clk);
            #1;
            if (rnd_ready) out_ready = 1'($urandom_range(0, 1));
        end
        in_valid  = 1'b0;
        in_bypass = 1'b0;
        check("accept_in_time", 32'(done), 32'd1);
    endtask

    task automatic drain();
        for (int i = 0; i < 200 && exp_q.size() != 0; i++) @(posedge clk);
        @(posedge clk);
        #1;
        check("drain_empty", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog expired actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt;
        nreset = 1'b0; clr = 1'b0; in_valid = 1'b0; in_bypass = 1'b0; out_ready = 1'b1;
        set_w(0);
        set_tex(0);

        // Reset values
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_outputs", 32'(got), 32'd0);
        @(posedge clk); #1;
        nreset = 1'b1;
        @(negedge clk);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk); #1;

        // T1 identity kernel on the centre tap, latency 3
        set_w(0);
        w[1][1] = 16'sd16384;
        set_tex(9);
        tex[0][1][1] = 8'd200; tex[1][1][1] = 8'd0; tex[2][1][1] = 8'd255;
        send_beat(1'b0, pk(200, 0, 255, 3'b000), 1'b1);

        // T2 saturation both ways
        set_w(16384);
        set_tex(255);
        send_beat(1'b0, pk(255, 255, 255, 3'b111), 1'b1);
        set_w(-16384);
        set_tex(10);
        send_beat(1'b0, pk(0, 0, 0, 3'b111), 1'b1);

        // T3 rounding: 0.5 -> 1, 1.0 -> 1... 1.5 -> 2; negatives
        set_w(0);
        w[0][0] = 16'sd8192; w[0][1] = 16'sd8192;
        set_tex(0);
        tex[0][0][0] = 8'd1; tex[0][0][1] = 8'd0;
        tex[1][0][0] = 8'd1; tex[1][0][1] = 8'd2;
        tex[2][0][0] = 8'd3; tex[2][0][1] = 8'd0;
        send_beat(1'b0, pk(1, 2, 2, 3'b000), 1'b1);
        w[0][0] = -16'sd8192; w[0][1] = 16'sd0;
        tex[0][0][0] = 8'd1; tex[1][0][0] = 8'd3; tex[2][0][0] = 8'd0;
        send_beat(1'b0, pk(0, 0, 0, 3'b010), 1'b1);
        drain();

        // T4 backpressure: three beats fill the pipe, fourth waits
        set_w(0);
        w[1][1] = 16'sd16384;
        set_tex(0);
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            for (int c = 0; c < CH; c++) tex[c][1][1] = CW'(i * 20 + c + 1);
            send_beat(1'b0, pk(i * 20 + 1, i * 20 + 2, i * 20 + 3, 3'b000), 1'b0);
        end
        for (int c = 0; c < CH; c++) tex[c][1][1] = CW'(60 + c + 1);
        in_valid = 1'b1;
        @(negedge clk);
        check("bp_in_ready_full", 32'(in_ready), 32'd0);
        check("bp_out_valid", 32'(out_valid), 32'd1);
        check("bp_hold_a", 32'(got), 32'(pk(1, 2, 3, 3'b000)));
        @(posedge clk); #1;
        @(negedge clk);
        check("bp_hold_b", 32'(got), 32'(pk(1, 2, 3, 3'b000)));
        check("bp_still_full", 32'(in_ready), 32'd0);
        @(posedge clk); #1;
        out_ready = 1'b1;
        send_beat(1'b0, pk(61, 62, 63, 3'b000), 1'b0);
        drain();

        // T5 interleaved bypass / filtered beats with random sink stalls
        set_w(0);
        w[2][2] = 16'sd16384;
        set_tex(77);
        rnd_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            logic byp;
            byp = 1'(i % 2);
            for (int c = 0; c < CH; c++) begin
                tex[c][1][1] = CW'(10 * i + c);
                tex[c][2][2] = CW'(100 + 10 * i + c);
            end
            if (byp) send_beat(1'b1, pk(10 * i, 10 * i + 1, 10 * i + 2, 3'b000), 1'b0);
            else     send_beat(1'b0, pk(100 + 10 * i, 101 + 10 * i, 102 + 10 * i, 3'b000), 1'b0);
        end
        rnd_ready = 1'b0;
        out_ready = 1'b1;
        drain();

        // T6 clr flushes three in-flight beats and blocks a simultaneous input
        set_w(0);
        w[1][1] = 16'sd16384;
        set_tex(5);
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) send_beat(1'b0, pk(5, 5, 5, 3'b000), 1'b0);
        in_valid = 1'b1;
        clr = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        check("clr_in_ready", 32'(in_ready), 32'd0);
        @(posedge clk); #1;
        clr = 1'b0;
        in_valid = 1'b0;
        exp_q.delete();
        lat_q.delete();
        @(negedge clk);
        check("clr_out_valid", 32'(out_valid), 32'd0);
        cnt = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (out_valid) cnt++;
        end
        check("clr_no_output", 32'(cnt), 32'd0);
        @(posedge clk); #1;
        for (int c = 0; c < CH; c++) tex[c][1][1] = CW'(40 + c);
        send_beat(1'b0, pk(40, 41, 42, 3'b000), 1'b1);
        drain();

        // Reset asserted with the pipe full
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) send_beat(1'b0, pk(40, 41, 42, 3'b000), 1'b0);
        nreset = 1'b0;
        #1;
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_outputs", 32'(got), 32'd0);
        exp_q.delete();
        lat_q.delete();
        @(posedge clk); #1;
        nreset = 1'b1;
        out_ready = 1'b1;
        for (int c = 0; c < CH; c++) tex[c][1][1] = CW'(250 + c);
        send_beat(1'b0, pk(250, 251, 252, 3'b000), 1'b1);
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
